// File: rtl/skew_shift_array.sv
// skew_shift_array -- per-lane registered delay lines (skew / de-skew) with in-flight beat counter
// Revision: 1.0
`default_nettype none

module skew_shift_array #(
  parameter int LANES      = 8,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 8,
  parameter int BASE_DELAY = 1,
  parameter int DESKEW     = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en_i,
  input  logic                                 flush_i,
  input  logic                                 in_valid_i,
  input  logic [TAG_W-1:0]                     in_tag_i,
  input  logic [LANES*DATA_W-1:0]              in_data_i,
  output logic [LANES-1:0]                     out_valid_o,
  output logic [LANES*TAG_W-1:0]               out_tag_o,
  output logic [LANES*DATA_W-1:0]              out_data_o,
  output logic [$clog2(BASE_DELAY+LANES)-1:0]  inflight_o,
  output logic                                 idle_o
);

  localparam int C_DMAX  = BASE_DELAY + LANES - 1;
  localparam int C_CNT_W = $clog2(C_DMAX + 1);
  localparam int C_LONG  = (DESKEW != 0) ? 0 : LANES - 1;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int DEPTH = (DESKEW != 0) ? (BASE_DELAY + LANES - 1 - l) : (BASE_DELAY + l);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    // Payload keeps shifting on empty beats; only the valid bit marks a real beat.
    always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (flush_i) begin
        valid_d = '0;
      end else if (en_i) begin
        valid_d[0] = in_valid_i;
        tag_d[0]   = in_tag_i;
        data_d[0]  = in_data_i[l*DATA_W +: DATA_W];
        for (int k = 1; k < DEPTH; k++) begin
          valid_d[k] = valid_q[k-1];
          tag_d[k]   = tag_q[k-1];
          data_d[k]  = data_q[k-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          tag_q[k]  <= '0;
          data_q[k] <= '0;
        end
      end else begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        data_q  <= data_d;
      end
    end

    assign out_valid_o[l]                   = valid_q[DEPTH-1];
    assign out_tag_o[l*TAG_W +: TAG_W]      = tag_q[DEPTH-1];
    assign out_data_o[l*DATA_W +: DATA_W]   = data_q[DEPTH-1];
  end

  logic [C_CNT_W-1:0] inflight_q, inflight_d;

  // A beat retires when it leaves the deepest lane; accept and retire together cancel.
  always_comb begin
    inflight_d = inflight_q;
    if (flush_i) begin
      inflight_d = '0;
    end else if (en_i) begin
      case ({in_valid_i, out_valid_o[C_LONG]})
        2'b10:   inflight_d = inflight_q + C_CNT_W'(1);
        2'b01:   inflight_d = inflight_q - C_CNT_W'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign inflight_o = inflight_q;
  assign idle_o     = (inflight_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_skew_shift_array.sv
// Bench for skew_shift_array: skew and de-skew instances share stimulus; per-lane scoreboard plus directed checks.
`default_nettype none

module tb_skew_shift_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i, flush_i, in_valid_i;
  logic [3:0]  in_tag_i;
  logic [31:0] in_data_i;

  logic [3:0]  ov   [2];
  logic [15:0] ot   [2];
  logic [31:0] od   [2];
  logic [2:0]  inf  [2];
  logic        idle [2];

  int n_chk  = 0;
  int n_pass = 0;
  int en_cnt = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic [3:0] tag;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb_q [8][$];

  always #5 clk = ~clk;

  skew_shift_array #(.LANES(4), .DATA_W(8), .TAG_W(4), .BASE_DELAY(1), .DESKEW(0)) u_skew (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_tag_i(in_tag_i), .in_data_i(in_data_i), .out_valid_o(ov[0]), .out_tag_o(ot[0]),
    .out_data_o(od[0]), .inflight_o(inf[0]), .idle_o(idle[0]));

  skew_shift_array #(.LANES(4), .DATA_W(8), .TAG_W(4), .BASE_DELAY(1), .DESKEW(1)) u_deskew (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_tag_i(in_tag_i), .in_data_i(in_data_i), .out_valid_o(ov[1]), .out_tag_o(ot[1]),
    .out_data_o(od[1]), .inflight_o(inf[1]), .idle_o(idle[1]));

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, m, $time, act, exp);
    else
      n_pass++;
  endtask

  function automatic int lane_delay(input int m, input int lane);
    return (m == 0) ? (1 + lane) : (4 - lane);
  endfunction

  // Expected-response producer: one entry per lane per accepted beat, due after the lane delay in enabled edges.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (en_i) en_cnt++;
      if (flush_i) begin
        for (int k = 0; k < 8; k++) sb_q[k].delete();
      end else if (en_i && in_valid_i) begin
        for (int m = 0; m < 2; m++)
          for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.tag  = in_tag_i;
            e.data = in_data_i[i*8 +: 8];
            e.due  = en_cnt + lane_delay(m, i) - 1;
            sb_q[m*4+i].push_back(e);
          end
      end
    end
  end

  always @(negedge rst_n) begin
    for (int k = 0; k < 8; k++) sb_q[k].delete();
  end

  // Monitor: compares every lane of both instances each cycle against the scoreboard head.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < 4; i++) begin
          int   k;
          logic ev;
          k = m*4 + i;
          while (sb_q[k].size() > 0 && sb_q[k][0].due < en_cnt) void'(sb_q[k].pop_front());
          ev = (sb_q[k].size() > 0) && (sb_q[k][0].due == en_cnt);
          chk($sformatf("mon_valid_l%0d", i), m, 32'(ov[m][i]), 32'(ev));
          if (ev && ov[m][i]) begin
            chk($sformatf("mon_tag_l%0d", i),  m, 32'(ot[m][i*4 +: 4]), 32'(sb_q[k][0].tag));
            chk($sformatf("mon_data_l%0d", i), m, 32'(od[m][i*8 +: 8]), 32'(sb_q[k][0].data));
          end
        end
    end
  end

  task automatic cyc(input logic en, input logic fl, input logic v, input logic [3:0] tag, input logic [31:0] d);
    en_i = en; flush_i = fl; in_valid_i = v; in_tag_i = tag; in_data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) cyc(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_tag_i = '0; in_data_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    mon_on = 1'b1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_inflight", m, 32'(inf[m]), 32'd0);
      chk("rst_idle",     m, 32'(idle[m]), 32'd1);
      chk("rst_data",     m, od[m], 32'h0);
      chk("rst_tag",      m, 32'(ot[m]), 32'h0);
    end

    // Skew single beat
    cyc(1'b1, 1'b0, 1'b1, 4'hA, 32'h44332211);
    chk("skew_l0_data", 0, 32'(od[0][7:0]), 32'h11);
    for (int c = 1; c <= 4; c++) begin
      chk("skew_valid",    0, 32'(ov[0]), 32'(4'b0001 << (c-1)));
      chk("skew_inflight", 0, 32'(inf[0]), 32'd1);
      if (c == 4) chk("skew_l3_data", 0, 32'(od[0][31:24]), 32'h44);
      idle_cycles(1);
    end
    chk("skew_drained_inflight", 0, 32'(inf[0]), 32'd0);
    chk("skew_drained_idle",     0, 32'(idle[0]), 32'd1);

    // De-skew alignment
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 4'h1, 32'hA3A2A1A0);
    chk("deskew_l3_first", 1, 32'(ov[1]), 32'h8);
    chk("deskew_l3_data",  1, 32'(od[1][31:24]), 32'hA3);
    cyc(1'b1, 1'b0, 1'b1, 4'h2, 32'hB3B2B1B0);
    cyc(1'b1, 1'b0, 1'b1, 4'h3, 32'hC3C2C1C0);
    cyc(1'b1, 1'b0, 1'b1, 4'h4, 32'hD3D2D1D0);
    idle_cycles(0);
    en_i = 1'b1; in_valid_i = 1'b0;
    chk("deskew_aligned_valid", 1, 32'(ov[1]), 32'hF);
    chk("deskew_aligned_data",  1, od[1], 32'hD3C2B1A0);
    chk("deskew_aligned_tag",   1, 32'(ot[1]), 32'h4321);
    chk("deskew_peak_inflight", 1, 32'(inf[1]), 32'd4);
    idle_cycles(6);
    chk("deskew_drained_idle", 1, 32'(idle[1]), 32'd1);

    // Stall, with in_valid_i asserted while stalled
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 4'h5, 32'h0D0C0B0A);
    idle_cycles(1);
    for (int c = 2; c <= 4; c++) begin
      chk("stall_hold_valid",    0, 32'(ov[0]), 32'h2);
      chk("stall_hold_data",     0, 32'(od[0][15:8]), 32'h0B);
      chk("stall_hold_inflight", 0, 32'(inf[0]), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 4'hF, 32'hFFFFFFFF);
    end
    idle_cycles(2);
    chk("stall_l3_valid", 0, 32'(ov[0]), 32'h8);
    chk("stall_l3_data",  0, 32'(od[0][31:24]), 32'h0D);
    idle_cycles(5);
    chk("stall_drained", 0, 32'(inf[0]), 32'd0);

    // Flush with simultaneous input beat
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 4'h6, 32'h66666666);
    cyc(1'b1, 1'b0, 1'b1, 4'h7, 32'h77777777);
    cyc(1'b1, 1'b1, 1'b1, 4'h8, 32'h88888888);
    for (int m = 0; m < 2; m++) begin
      chk("flush_valid",    m, 32'(ov[m]), 32'h0);
      chk("flush_inflight", m, 32'(inf[m]), 32'd0);
      chk("flush_idle",     m, 32'(idle[m]), 32'd1);
    end
    idle_cycles(5);
    for (int m = 0; m < 2; m++) chk("flush_stays_empty", m, 32'(inf[m]), 32'd0);

    // Back-to-back accepts
    do_reset();
    for (int j = 0; j < 10; j++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'(j), 32'h30201000 + 32'(j) * 32'h01010101);
      for (int m = 0; m < 2; m++)
        chk("b2b_inflight", m, 32'(inf[m]), (j + 1 < 4) ? 32'(j + 1) : 32'd4);
    end
    idle_cycles(6);
    for (int m = 0; m < 2; m++) chk("b2b_drained", m, 32'(inf[m]), 32'd0);

    // Asynchronous reset mid-flight, then first accept right after release
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 4'h9, 32'h99999999);
    cyc(1'b1, 1'b0, 1'b1, 4'hB, 32'hBBBBBBBB);
    en_i = 1'b1; in_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("async_rst_valid",    m, 32'(ov[m]), 32'h0);
      chk("async_rst_data",     m, od[m], 32'h0);
      chk("async_rst_tag",      m, 32'(ot[m]), 32'h0);
      chk("async_rst_inflight", m, 32'(inf[m]), 32'd0);
      chk("async_rst_idle",     m, 32'(idle[m]), 32'd1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(6);
    cyc(1'b1, 1'b0, 1'b1, 4'hC, 32'hCCCCCCCC);
    chk("post_rst_accept_valid",    0, 32'(ov[0]), 32'h1);
    chk("post_rst_accept_inflight", 0, 32'(inf[0]), 32'd1);
    idle_cycles(6);

    for (int k = 0; k < 8; k++) chk("scoreboard_empty", k / 4, 32'(sb_q[k].size()), 32'd0);

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
